muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline.
- Sits in the execute stage, beside the ALU. It accepts one mult/div/mthi/mtlo operation per start pulse.
- Counts out a fixed latency, commits results to HI/LO, and generates the decode-stage stall request that holds back dependent or competing md instructions.

---
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit with HI/LO registers for the
// execute stage. One operation is accepted per start pulse. A mult/div counts
// out a fixed latency and then commits to HI/LO. The unit also raises the
// decode-stage stall request for dependent or competing md instructions.
// Optional build macro MULDIV_MADD_EN enables madd/maddu/msub/msubu (ops 6-9).
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic [31:0]     hi_r;
  logic [31:0]     lo_r;
  logic [31:0]     pend_hi_r;
  logic [31:0]     pend_lo_r;
  logic            pend_ok_r;

  logic            is_mul_s;
  logic            is_div_s;
  logic            sgn_s;
  logic [63:0]     rs_ext_s;
  logic [63:0]     rt_ext_s;
  logic [63:0]     prod_s;
  logic            rs_neg_s;
  logic            rt_neg_s;
  logic [31:0]     rs_mag_s;
  logic [31:0]     rt_mag_s;
  logic [31:0]     divisor_s;
  logic [31:0]     uq_s;
  logic [31:0]     ur_s;
  logic [31:0]     div_q_s;
  logic [31:0]     div_r_s;
  logic [63:0]     res_s;
  logic            res_ok_s;
  logic            stall_md_s;

  // Classify the opcode into long-latency multiply-class and divide-class ops
  always_comb begin
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    case (op)
      4'd0, 4'd1: is_mul_s = 1'b1;
      4'd2, 4'd3: is_div_s = 1'b1;
`ifdef MULDIV_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: is_mul_s = 1'b1;
`endif
      default: begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
      end
    endcase
  end

  // Signed variants are the even opcodes; sign-extend operands and multiply at 64 bits
  always_comb begin
    sgn_s    = ~op[0];
    rs_ext_s = {((sgn_s & rs_val[31]) ? 32'hFFFF_FFFF : 32'h0000_0000), rs_val};
    rt_ext_s = {((sgn_s & rt_val[31]) ? 32'hFFFF_FFFF : 32'h0000_0000), rt_val};
    prod_s   = rs_ext_s * rt_ext_s;
  end

  // Divide on magnitudes, then restore signs (quotient toward zero, remainder follows rs)
  always_comb begin
    rs_neg_s  = sgn_s & rs_val[31];
    rt_neg_s  = sgn_s & rt_val[31];
    rs_mag_s  = rs_neg_s ? (32'd0 - rs_val) : rs_val;
    rt_mag_s  = rt_neg_s ? (32'd0 - rt_val) : rt_val;
    // a zero divisor is replaced so the divider never sees x/0; its result is discarded anyway
    divisor_s = (rt_val == 32'd0) ? 32'd1 : rt_mag_s;
    uq_s      = rs_mag_s / divisor_s;
    ur_s      = rs_mag_s % divisor_s;
    div_q_s   = (rs_neg_s ^ rt_neg_s) ? (32'd0 - uq_s) : uq_s;
    div_r_s   = rs_neg_s ? (32'd0 - ur_s) : ur_s;
  end

  // Select the value to park in the pending registers and whether it may commit
  always_comb begin
    res_s    = prod_s;
    res_ok_s = 1'b1;
    if (is_div_s) begin
      res_s    = {div_r_s, div_q_s};
      res_ok_s = (rt_val != 32'd0);
    end else begin
`ifdef MULDIV_MADD_EN
      case (op)
        4'd6, 4'd7: res_s = {hi_r, lo_r} + prod_s;
        4'd8, 4'd9: res_s = {hi_r, lo_r} - prod_s;
        default:    res_s = prod_s;
      endcase
`else
      res_s = prod_s;
`endif
      res_ok_s = 1'b1;
    end
  end

  // State register; busy tracks the RUN state as a registered output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
    end
  end

  // Next-state logic: enter RUN on a long op, leave when the last count expires
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (is_mul_s || is_div_s)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Counter, pending result and HI/LO updates; starts during RUN are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= '0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_ok_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (start && is_mul_s) begin
        cnt_r     <= CW'(MUL_CYCLES);
        pend_hi_r <= res_s[63:32];
        pend_lo_r <= res_s[31:0];
        pend_ok_r <= res_ok_s;
      end else if (start && is_div_s) begin
        cnt_r     <= CW'(DIV_CYCLES);
        pend_hi_r <= res_s[63:32];
        pend_lo_r <= res_s[31:0];
        pend_ok_r <= res_ok_s;
      end else if (start && (op == 4'd4)) begin
        hi_r <= rs_val;
      end else if (start && (op == 4'd5)) begin
        lo_r <= rs_val;
      end
    end else begin
      cnt_r <= cnt_r - CW'(1);
      if ((cnt_r == CW'(1)) && pend_ok_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end
    end
  end

  // Output logic: stall dependent/competing md instructions in decode
  always_comb begin
    stall_md_s = md_in_d & (busy_r | (start & (is_mul_s | is_div_s)));
  end

  assign busy     = busy_r;
  assign stall_md = stall_md_s;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written
// reset/back-to-back sequences, and randomized ops against an arithmetic model.
module tb_muldiv_ctrl;

  localparam int MUL = 5;
  localparam int DIV = 10;
`ifdef MULDIV_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_in_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

  muldiv_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .md_in_d(md_in_d), .busy(busy), .stall_md(stall_md),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair
  task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    int     ia, ib;
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    cyc = 0;
    case (o)
      4'd0: begin p = sa * sb; {h, l} = p; cyc = MUL; end
      4'd1: begin p = ua * ub; {h, l} = p; cyc = MUL; end
      4'd2: begin
        cyc = DIV;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      4'd3: begin
        cyc = DIV;
        if (b != 32'd0) begin q = ua / ub; r = ua % ub; l = q[31:0]; h = r[31:0]; end
      end
      4'd4: h = a;
      4'd5: l = a;
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (MADD) begin
          p = (o[0] == 1'b0) ? sa * sb : ua * ub;
          if (o <= 4'd7) {h, l} = {h, l} + p;
          else           {h, l} = {h, l} - p;
          cyc = MUL;
        end
      end
      default: cyc = 0;
    endcase
  endtask

  // Issue one op, check stall_md on the start cycle and during busy, count busy cycles
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic md, output int cyc);
    logic exp_st;
    @(posedge clk); #2;
    start = 1'b1; op = o; rs_val = a; rt_val = b; md_in_d = md;
    #1;
    exp_st = md && ((o <= 4'd3) || (MADD && (o >= 4'd6) && (o <= 4'd9)));
    check("stall_at_start", 64'(stall_md), 64'(exp_st));
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (busy && (cyc < 40)) begin
      check("stall_while_busy", 64'(stall_md), 64'(md));
      cyc++;
      @(posedge clk); #2;
    end
    md_in_d = 1'b0;
  endtask

  // A start while the unit is busy would be a hazard-unit violation
  always @(negedge clk) begin
    if (rst_n && start && busy) begin
      fails++;
      $display("FAIL start_while_busy: got start=1 busy=1 required no start while busy");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] mh, ml;
    logic [31:0] a, b;
    logic [3:0]  o;
    int          mcyc;
    logic [31:0] specials [4];

    tests = 0; fails = 0;
    start = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; md_in_d = 1'b0;
    rst_n = 1'b0;
    specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL};
    vecs[1]  = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL};
    vecs[2]  = '{4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV};
    vecs[3]  = '{4'd3, 32'd7,         32'd2, 32'h0000_0001, 32'h0000_0003, DIV};
    vecs[4]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV};
    vecs[5]  = '{4'd4, 32'h11,        32'd0, 32'h11, 32'h8000_0000, 0};
    vecs[6]  = '{4'd5, 32'h22,        32'd0, 32'h11, 32'h22, 0};
    vecs[7]  = '{4'd2, 32'd5,         32'd0, 32'h11, 32'h22, DIV};
    vecs[8]  = '{4'd4, 32'h0,         32'd0, 32'h0,  32'h22, 0};
    vecs[9]  = '{4'd5, 32'hFFFF_FFFF, 32'd0, 32'h0,  32'hFFFF_FFFF, 0};
`ifdef MULDIV_MADD_EN
    vecs[10] = '{4'd7, 32'd1, 32'd1, 32'h1, 32'h0, MUL};
    vecs[11] = '{4'd12, 32'd9, 32'd9, 32'h1, 32'h0, 0};
`else
    vecs[10] = '{4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[11] = '{4'd12, 32'd9, 32'd9, 32'h0, 32'hFFFF_FFFF, 0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    md_in_d = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_stall", 64'(stall_md), 64'd0);
    md_in_d = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'(i % 2), cyc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].ecyc));
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
    end

    // Reset in the middle of a multiply aborts it without commit
    run_op(4'd4, 32'h55, 32'd0, 1'b0, cyc);
    @(posedge clk); #2;
    start = 1'b1; op = 4'd0; rs_val = 32'd7; rt_val = 32'd6;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("midreset_nocommit_hi", 64'(hi), 64'd0);
    check("midreset_nocommit_lo", 64'(lo), 64'd0);
    check("midreset_nocommit_busy", 64'(busy), 64'd0);
    mh = 32'd0; ml = 32'd0;

    // mthi immediately followed by mult on the next cycle
    @(posedge clk); #2;
    start = 1'b1; op = 4'd4; rs_val = 32'h0000_ABCD; rt_val = 32'd0;
    @(posedge clk); #2;
    op = 4'd0; rs_val = 32'hFFFF_FFF0; rt_val = 32'h0000_0100;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (busy && (cyc < 40)) begin
      cyc++;
      @(posedge clk); #2;
    end
    model_op(4'd4, 32'h0000_ABCD, 32'd0, mh, ml, mcyc);
    model_op(4'd0, 32'hFFFF_FFF0, 32'h0000_0100, mh, ml, mcyc);
    check("b2b_cycles", 64'(cyc), 64'(mcyc));
    check("b2b_hi", 64'(hi), 64'(mh));
    check("b2b_lo", 64'(lo), 64'(ml));

    // Randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      o = 4'($urandom_range(0, 11));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      model_op(o, a, b, mh, ml, mcyc);
      run_op(o, a, b, 1'($urandom_range(0, 1)), cyc);
      check($sformatf("rnd%0d_op%0d_cycles", n, o), 64'(cyc), 64'(mcyc));
      check($sformatf("rnd%0d_op%0d_hi", n, o), 64'(hi), 64'(mh));
      check($sformatf("rnd%0d_op%0d_lo", n, o), 64'(lo), 64'(ml));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
